uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

ASCII command parser that sits between `uart_rx` and `uart_tx` in the DE10-Standard UART/LED design, replacing raw echo-back. It accepts line-based commands to write or read the 10-bit LED register. It drives `LEDR` directly and returns a short ASCII reply per command through the `uart_tx` start/busy handshake.

## Interface
- `LED_W`, 10: width of LED register (max 12).
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles before a partial command is aborted (only with timeout feature).

- `CLOCK_50`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  received byte; valid only when `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `tx_busy`  in  1  high while `uart_tx` is shifting a byte.
- `tx_data`  out  8  reply byte to `uart_tx`.
- `tx_start`  out  1  one-cycle request to transmit `tx_data`.
- `led_out`  out  LED_W  LED register.
- `cmd_ok`  out  1  one-cycle pulse on successful command.
- `cmd_err`  out  1  one-cycle pulse on rejected or aborted command.
- `parser_busy`  out  1  high in any state other than IDLE.

## Operation
- Grammar: `L<h>[h][h]<term>` writes; `R<term>` reads.
  - `<term>` is CR (0x0D) or LF (0x0A).
  - `L`/`R` are case-insensitive. Hex digits are 0-9, A-F, a-f.
- FSM states: IDLE, WR_DIG, RD_TERM, ERR_SKIP, REPLY.
- IDLE:
  - `L` -> WR_DIG, clear accumulator and digit count.
  - `R` -> RD_TERM.
  - Terminator -> stay in IDLE, silently.
  - Any other byte -> ERR_SKIP.
- WR_DIG:
  - Hex digit with count < 3: `acc = {acc[7:0], nibble}` (12-bit), count += 1.
  - Terminator with count >= 1 and `acc <= 2^LED_W-1`: `led_out <= acc[LED_W-1:0]`, reply `K\r\n`, pulse `cmd_ok`.
  - Terminator with count 0, or with acc out of range: reply `E\r\n`, pulse `cmd_err`, `led_out` unchanged.
  - 4th digit or non-hex byte -> ERR_SKIP.
- RD_TERM:
  - Terminator: reply 3 uppercase hex digits of zero-extended `led_out` plus `\r\n` (e.g. `2A5\r\n`), pulse `cmd_ok`.
  - Other byte -> ERR_SKIP.
- ERR_SKIP: discard bytes until a terminator, then reply `E\r\n` and pulse `cmd_err`.
- REPLY: send 3 or 5 queued bytes in order, then go to IDLE.
  - `rx_valid` bytes arriving in REPLY are dropped, not parsed.
- Reset values: `led_out` 0, `tx_data` 0x00, `tx_start` 0, `cmd_ok` 0, `cmd_err` 0, `parser_busy` 0, FSM in IDLE.
- Reset mid-operation: partial command and pending reply are discarded; no further `tx_start`.

## Timing
- A byte is consumed on the rising edge where `rx_valid`=1.
- After a write terminator is consumed at edge N:
  - `led_out`, `cmd_ok`/`cmd_err` update at N+1.
  - FSM enters REPLY at N+1.
- TX handshake, per reply byte:
  - `tx_start`=1 for exactly one cycle, issued only when `tx_busy`=0, with `tx_data` valid in that same cycle.
  - `tx_data` then held until the next byte is issued.
  - After each `tx_start`, wait one guard cycle, then wait for `tx_busy`=0 before issuing the next byte.
  - First `tx_start` occurs no earlier than N+1.
- `cmd_ok` and `cmd_err` are never high together.
- `parser_busy` is high from the edge after a non-terminator byte is consumed in IDLE until the last reply byte's `tx_busy` falls.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - A 26-bit counter runs in WR_DIG, RD_TERM and ERR_SKIP, and is cleared on each consumed byte.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, pulse `cmd_err`, send no reply.
  - The counter is inactive in IDLE and REPLY.
- Undefined: no counter; partial commands persist indefinitely.

## Structure
- Package `uart_cmd_pkg`:
  - FSM state encoding.
  - ASCII constants (CR, LF, `K`, `E`, `L`, `R`).
  - Functions `hex_to_nibble`, `is_hex`, `nibble_to_ascii`.
- Sub-module `uart_reply_seq`:
  - Loads up to 5 bytes plus a length.
  - Owns `tx_start`/`tx_data` and the guard/busy handshake.
  - Returns a `done` pulse.

## Test plan
- Send `L2A5\r` -> `led_out`=0x2A5 one cycle after CR; TX bytes `K`,`\r`,`\n`; one `cmd_ok` pulse.
- After that, send `r\n` -> TX `2`,`A`,`5`,`\r`,`\n`; `led_out` unchanged.
- Send `L400\r` -> TX `E\r\n`, `cmd_err` pulse, `led_out` keeps its previous value. Send `L1234\r` (4th digit) -> ERR_SKIP, then TX `E\r\n`.
- Hold `tx_busy` high 5000 cycles after each `tx_start` -> no second `tx_start` until `tx_busy` falls; `tx_data` stable throughout.
- Assert `rst_n` low mid-reply after the 2nd byte -> all outputs at reset values; no further `tx_start`; a following `R\r` is answered `000\r\n`.
- With `UART_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send `L3`, then idle 100 cycles -> `cmd_err` pulse, FSM in IDLE, no TX; a subsequent `R\r` returns the old value.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: state encodings, ASCII constants and hex helpers shared by the UART command parser.
package uart_cmd_pkg;
   typedef enum logic [2:0] {IDLE, WR_DIG, RD_TERM, ERR_SKIP, REPLY} state_t;
   typedef enum logic [2:0] {SQ_IDLE, SQ_SEND, SQ_START, SQ_GUARD, SQ_WAIT} seq_state_t;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_K  = 8'h4B;
   localparam logic [7:0] ASC_E  = 8'h45;
   localparam logic [7:0] ASC_L  = 8'h4C;
   localparam logic [7:0] ASC_R  = 8'h52;
   function automatic logic is_term(input logic [7:0] c);
      return c == ASC_CR || c == ASC_LF;
   endfunction
   function automatic logic is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
   endfunction
   function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
      return c <= 8'h39 ? c[3:0] : c[3:0] + 4'd9;
   endfunction
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction
endpackage

// File: rtl/uart_reply_seq.sv
// uart_reply_seq: sends a queued reply of up to 5 bytes through the uart_tx start/busy handshake.
module uart_reply_seq import uart_cmd_pkg::*; (
   input  logic            CLOCK_50,
   input  logic            rst_n,
   input  logic            load,
   input  logic [4:0][7:0] bytes_in,
   input  logic [2:0]      len,
   input  logic            tx_busy,
   output logic [7:0]      tx_data,
   output logic            tx_start,
   output logic            done
);
   seq_state_t state_q, state_d;
   logic [4:0][7:0] data_q, data_d;
   logic [2:0] len_q, len_d, idx_q, idx_d;
   logic [7:0] tx_data_q, tx_data_d;
   always_comb begin
      state_d = state_q;
      data_d = data_q;
      len_d = len_q;
      idx_d = idx_q;
      tx_data_d = tx_data_q;
      done = 1'b0;
      case (state_q)
         SQ_IDLE: if (load) begin
            data_d = bytes_in;
            len_d = len;
            idx_d = 3'd0;
            state_d = SQ_SEND;
         end
         SQ_SEND: if (!tx_busy) begin
            tx_data_d = data_q[idx_q];
            state_d = SQ_START;
         end
         SQ_START: state_d = SQ_GUARD;
         // guard cycle gives uart_tx time to raise busy before it is sampled
         SQ_GUARD: state_d = SQ_WAIT;
         SQ_WAIT: if (!tx_busy) begin
            done = idx_q == len_q - 3'd1;
            idx_d = idx_q + 3'd1;
            state_d = done ? SQ_IDLE : SQ_SEND;
         end
         default: state_d = SQ_IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) begin
         state_q <= SQ_IDLE;
         data_q <= '0;
         len_q <= 3'd0;
         idx_q <= 3'd0;
         tx_data_q <= 8'h00;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
         len_q <= len_d;
         idx_q <= idx_d;
         tx_data_q <= tx_data_d;
      end
   assign tx_start = state_q == SQ_START;
   assign tx_data = tx_data_q;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses L<hex>/R line commands to write/read the LED register and queues ASCII replies.
module uart_cmd_parser import uart_cmd_pkg::*; #(
  parameter int LED_W = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [LED_W-1:0] led_out,
  output logic             cmd_ok,
  output logic             cmd_err,
  output logic             parser_busy
);
  state_t state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic ok_q, ok_d, err_q, err_d;
  logic load, seq_done, term, tmo_hit;
  logic [4:0][7:0] rep_bytes;
  logic [2:0] rep_len;
  logic [11:0] led12;
  assign term = is_term(rx_data);
  assign led12 = 12'(led_q);
`ifdef UART_CMD_TIMEOUT_EN
  logic [25:0] tmo_q, tmo_d;
  assign tmo_hit = tmo_q == 26'(TIMEOUT_CYCLES);
  assign tmo_d = (state_q inside {WR_DIG, RD_TERM, ERR_SKIP}) && !rx_valid && !tmo_hit ? tmo_q + 26'd1 : 26'd0;
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) tmo_q <= 26'd0;
    else tmo_q <= tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    led_d = led_q;
    ok_d = 1'b0;
    err_d = 1'b0;
    load = 1'b0;
    rep_bytes = {8'h00, 8'h00, ASC_LF, ASC_CR, ASC_E};
    rep_len = 3'd3;
    case (state_q)
      IDLE: if (rx_valid) begin
        acc_d = 12'd0;
        cnt_d = 2'd0;
        state_d = (rx_data & 8'hDF) == ASC_L ? WR_DIG :
                  (rx_data & 8'hDF) == ASC_R ? RD_TERM :
                  term ? IDLE : ERR_SKIP;
      end
      WR_DIG: if (rx_valid) begin
        if (is_hex(rx_data) && cnt_q != 2'd3) begin
          acc_d = {acc_q[7:0], hex_to_nibble(rx_data)};
          cnt_d = cnt_q + 2'd1;
        end else if (term) begin
          load = 1'b1;
          state_d = REPLY;
          ok_d = cnt_q != 2'd0 && (acc_q >> LED_W) == 12'd0;
          err_d = !ok_d;
          led_d = ok_d ? acc_q[LED_W-1:0] : led_q;
          rep_bytes[0] = ok_d ? ASC_K : ASC_E;
        end else state_d = ERR_SKIP;
      end
      RD_TERM: if (rx_valid) begin
        if (term) begin
          load = 1'b1;
          state_d = REPLY;
          ok_d = 1'b1;
          rep_len = 3'd5;
          rep_bytes = {ASC_LF, ASC_CR, nibble_to_ascii(led12[3:0]),
                       nibble_to_ascii(led12[7:4]), nibble_to_ascii(led12[11:8])};
        end else state_d = ERR_SKIP;
      end
      ERR_SKIP: if (rx_valid && term) begin
        load = 1'b1;
        state_d = REPLY;
        err_d = 1'b1;
      end
      REPLY: state_d = seq_done ? IDLE : REPLY;
      default: state_d = IDLE;
    endcase
    if (tmo_hit && !rx_valid) begin
      state_d = IDLE;
      ok_d = 1'b0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= 12'd0;
      cnt_q <= 2'd0;
      led_q <= '0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
      ok_q <= ok_d;
      err_q <= err_d;
    end
  uart_reply_seq u_seq (
    .CLOCK_50(CLOCK_50),
    .rst_n(rst_n),
    .load(load),
    .bytes_in(rep_bytes),
    .len(rep_len),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .done(seq_done)
  );
  assign led_out = led_q;
  assign cmd_ok = ok_q;
  assign cmd_err = err_q;
  assign parser_busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed commands with a TX/event scoreboard checked by a negedge monitor.
module tb_uart_cmd_parser;
  logic CLOCK_50 = 1'b0;
  logic rst_n, rx_valid, tx_busy, tx_start, cmd_ok, cmd_err, parser_busy;
  logic [7:0] rx_data, tx_data, last_data;
  logic [9:0] led_out;
  logic [7:0] exp_tx[$];
  logic [1:0] exp_ev[$];
  int total = 0, bad = 0, start_cnt = 0, bcnt = 0, blen = 10;
  uart_cmd_parser #(.LED_W(10), .TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .led_out(led_out),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err), .parser_busy(parser_busy)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  always @(posedge CLOCK_50) begin
    if (!rst_n) bcnt = 0;
    else if (tx_start) bcnt = blen;
    else if (bcnt != 0) bcnt--;
    #1 tx_busy = bcnt != 0;
  end
  always @(negedge CLOCK_50) if (rst_n) begin
    if (tx_start) begin
      start_cnt++;
      chk("start_while_busy", tx_busy, 0);
      if (exp_tx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tx: got %0h, want no byte", tx_data);
      end else chk("tx_byte", tx_data, exp_tx.pop_front());
      last_data = tx_data;
    end else if (tx_busy) chk("tx_hold", tx_data, last_data);
    if (cmd_ok || cmd_err) begin
      chk("ok_err_excl", cmd_ok & cmd_err, 0);
      if (exp_ev.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got ok=%0b err=%0b, want none", cmd_ok, cmd_err);
      end else chk("cmd_pulse", {cmd_ok, cmd_err}, exp_ev.pop_front());
    end
  end
  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
  endtask
  task automatic cmd(input string body, input logic [7:0] term, input string rep, input logic [1:0] ev);
    for (int i = 0; i < rep.len(); i++) exp_tx.push_back(rep[i]);
    if (rep.len() != 0) begin
      exp_tx.push_back(8'h0D);
      exp_tx.push_back(8'h0A);
    end
    if (ev != 2'b00) exp_ev.push_back(ev);
    for (int i = 0; i < body.len(); i++) send(body[i]);
    if (term != 8'h00) send(term);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((parser_busy || tx_busy) && n < 40000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("idle_wait", n < 40000, 1);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int base;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_led", led_out, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ok_err", {cmd_ok, cmd_err}, 0);
    chk("rst_busy", parser_busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    cmd("L2A5", 8'h00, "K", 2'b10);
    chk("led_before_cr", led_out, 10'h000);
    send(8'h0D);
    chk("led_after_cr", led_out, 10'h2A5);
    chk("ok_after_cr", cmd_ok, 1);
    wait_idle();
    cmd("r", 8'h0A, "2A5", 2'b10);
    wait_idle();
    chk("led_after_read", led_out, 10'h2A5);
    cmd("L400", 8'h0D, "E", 2'b01);
    chk("err_range", cmd_err, 1);
    chk("led_range", led_out, 10'h2A5);
    wait_idle();
    cmd("L1234", 8'h0D, "E", 2'b01);
    wait_idle();
    cmd("L", 8'h0D, "E", 2'b01);
    wait_idle();
    cmd("LG", 8'h0D, "E", 2'b01);
    wait_idle();
    cmd("Q", 8'h0D, "E", 2'b01);
    wait_idle();
    cmd("", 8'h0D, "", 2'b00);
    @(negedge CLOCK_50);
    chk("bare_term_idle", parser_busy, 0);
    cmd("RX", 8'h0D, "E", 2'b01);
    wait_idle();
    cmd("l3fF", 8'h0A, "K", 2'b10);
    wait_idle();
    chk("led_3ff", led_out, 10'h3FF);
    blen = 5000;
    cmd("R", 8'h0D, "3FF", 2'b10);
    wait_idle();
    blen = 10;
    cmd("R", 8'h0D, "3FF", 2'b10);
    send("L");
    send("5");
    send(8'h0D);
    wait_idle();
    chk("led_dropped", led_out, 10'h3FF);
    cmd("l1a", 8'h0D, "K", 2'b10);
    wait_idle();
    cmd("R", 8'h0A, "01A", 2'b10);
    wait_idle();
`ifdef UART_CMD_TIMEOUT_EN
    base = start_cnt;
    cmd("L3", 8'h00, "", 2'b01);
    repeat (120) @(negedge CLOCK_50);
    chk("tmo_idle", parser_busy, 0);
    chk("tmo_no_tx", start_cnt, base);
    cmd("R", 8'h0D, "01A", 2'b10);
    wait_idle();
`endif
    base = start_cnt;
    cmd("R", 8'h0D, "01A", 2'b10);
    for (int n = 0; n < 200 && start_cnt < base + 2; n++) @(negedge CLOCK_50);
    chk("two_starts", start_cnt, base + 2);
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b0;
    exp_tx.delete();
    exp_ev.delete();
    #1;
    chk("mid_rst_led", led_out, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_ok_err", {cmd_ok, cmd_err}, 0);
    chk("mid_rst_busy", parser_busy, 0);
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;
    base = start_cnt;
    repeat (60) @(negedge CLOCK_50);
    chk("no_tx_after_rst", start_cnt, base);
    cmd("R", 8'h0D, "000", 2'b10);
    wait_idle();
    repeat (5) @(negedge CLOCK_50);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("ev_queue_empty", exp_ev.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
